// File: rtl/vga_pixel_bridge.sv
// CPU bus front end for the 160x120 one-bit VGA frame buffer: coordinate/colour
// registers, pixel write/read-refresh and frame interrupt. Build option: VGA_PIXEL_BRIDGE_AUTOINC_EN.
module vga_pixel_bridge #(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int         FB_ADDR_W = 15
) (
  input  logic                 CLK,
  input  logic                 RESET,
  inout  wire  [7:0]           BUS_DATA,
  input  logic [7:0]           BUS_ADDR,
  input  logic                 BUS_WE,
  output logic                 BUS_INTERRUPT_RAISE,
  input  logic                 BUS_INTERRUPT_ACK,
  input  logic                 VGA_VS,
  output logic [FB_ADDR_W-1:0] FB_ADDR,
  output logic                 FB_WDATA,
  output logic                 FB_WE,
  input  logic                 FB_RDATA,
  output logic [15:0]          CONFIG_COLOURS
);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_CAPT} state_t;

  localparam logic [7:0] OFF_X      = 8'd0;
  localparam logic [7:0] OFF_Y      = 8'd1;
  localparam logic [7:0] OFF_PIXEL  = 8'd2;
  localparam logic [7:0] OFF_STATUS = 8'd3;
  localparam logic [7:0] OFF_BG     = 8'd4;
  localparam logic [7:0] OFF_FG     = 8'd5;
  localparam logic [7:0] OFF_FRAMES = 8'd6;

  state_t               state_q, state_d;
  logic [7:0]           x_q, x_d, y_q, y_d, bg_q, bg_d, fg_q, fg_d, frames_q, frames_d;
  logic                 pix_q, pix_d, err_q, err_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic                 fb_wdata_q, fb_wdata_d, fb_we_q, fb_we_d;
  logic                 raise_q, raise_d, vs_prev_q, vs_prev_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic                 rd_en_q, rd_en_d;

  logic [7:0]           off;
  logic                 mapped, busy, in_range, vs_fall;
  logic [FB_ADDR_W-1:0] pix_addr;

  assign off      = BUS_ADDR - BASE_ADDR;
  assign mapped   = (off < 8'd7);
  assign busy     = (state_q != IDLE);
  assign in_range = (x_q < 8'd160) && (y_q < 8'd120);
  assign vs_fall  = vs_prev_q & ~VGA_VS;
  // Y[7] and the upper X codes are excluded by in_range before this is used.
  assign pix_addr = FB_ADDR_W'({y_q[6:0], x_q});

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    bg_d       = bg_q;
    fg_d       = fg_q;
    frames_d   = frames_q;
    pix_d      = pix_q;
    err_d      = err_q;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    fb_we_d    = 1'b0;
    raise_d    = raise_q;
    vs_prev_d  = VGA_VS;
    rd_data_d  = 8'h00;
    rd_en_d    = 1'b0;

    case (state_q)
      RD_ADDR: state_d = RD_CAPT;
      RD_CAPT: begin
        pix_d   = FB_RDATA;
        state_d = IDLE;
      end
      default: state_d = state_q;
    endcase

    if (mapped && BUS_WE) begin
      case (off)
        OFF_X:      x_d = BUS_DATA;
        OFF_Y:      y_d = BUS_DATA;
        OFF_PIXEL: begin
          if (busy || !in_range) begin
            err_d = 1'b1;
          end else begin
            fb_we_d    = 1'b1;
            fb_addr_d  = pix_addr;
            fb_wdata_d = BUS_DATA[0];
`ifdef VGA_PIXEL_BRIDGE_AUTOINC_EN
            if (x_q == 8'd159) begin
              x_d = 8'd0;
              y_d = (y_q == 8'd119) ? 8'd0 : y_q + 8'd1;
            end else begin
              x_d = x_q + 8'd1;
            end
`endif
          end
        end
        OFF_STATUS: err_d = 1'b0;
        OFF_BG:     bg_d = BUS_DATA;
        OFF_FG:     fg_d = BUS_DATA;
        default:    ;
      endcase
    end

    if (mapped && !BUS_WE) begin
      rd_en_d = 1'b1;
      case (off)
        OFF_X:      rd_data_d = x_q;
        OFF_Y:      rd_data_d = y_q;
        OFF_PIXEL:  rd_data_d = {7'b0, pix_q};
        OFF_STATUS: rd_data_d = {6'b0, err_q, busy};
        OFF_BG:     rd_data_d = bg_q;
        OFF_FG:     rd_data_d = fg_q;
        default:    rd_data_d = frames_q;
      endcase
      // A PIXEL read returns the stale value and launches a refresh for next time.
      if (off == OFF_PIXEL) begin
        if (busy || !in_range) begin
          err_d = 1'b1;
        end else begin
          state_d   = RD_ADDR;
          fb_addr_d = pix_addr;
        end
      end
    end

    if (vs_fall) begin
      frames_d = frames_q + 8'd1;
      raise_d  = 1'b1;
    end else if (BUS_INTERRUPT_ACK) begin
      raise_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      x_q        <= 8'h00;
      y_q        <= 8'h00;
      bg_q       <= 8'h00;
      fg_q       <= 8'h00;
      frames_q   <= 8'h00;
      pix_q      <= 1'b0;
      err_q      <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= 1'b0;
      fb_we_q    <= 1'b0;
      raise_q    <= 1'b0;
      vs_prev_q  <= 1'b1;
      rd_data_q  <= 8'h00;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      bg_q       <= bg_d;
      fg_q       <= fg_d;
      frames_q   <= frames_d;
      pix_q      <= pix_d;
      err_q      <= err_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
      fb_we_q    <= fb_we_d;
      raise_q    <= raise_d;
      vs_prev_q  <= vs_prev_d;
      rd_data_q  <= rd_data_d;
      rd_en_q    <= rd_en_d;
    end
  end

  assign BUS_DATA            = rd_en_q ? rd_data_q : 8'hzz;
  assign FB_ADDR             = fb_addr_q;
  assign FB_WDATA            = fb_wdata_q;
  assign FB_WE               = fb_we_q;
  assign BUS_INTERRUPT_RAISE = raise_q;
  assign CONFIG_COLOURS      = {fg_q, bg_q};

endmodule

// File: tb/tb_vga_pixel_bridge.sv
// Scoreboard bench for vga_pixel_bridge: expected bus read data and frame-buffer
// writes are queued when stimulus is driven and popped when the DUT responds.
module tb_vga_pixel_bridge;
  logic        clk = 1'b0;
  logic        rst;
  wire  [7:0]  bus_data;
  logic [7:0]  bus_wdata, bus_addr;
  logic        bus_we, drive_en, ack, vs, fb_rdata;
  logic        raise, fb_wdata, fb_we;
  logic [14:0] fb_addr;
  logic [15:0] colours;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] fb_q[$];
  logic [7:0]  rd_q[$];
  bit          fb_mem [0:32767];

  assign bus_data = drive_en ? bus_wdata : 8'hzz;
  always #5 clk = ~clk;

  vga_pixel_bridge dut (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
    .BUS_INTERRUPT_RAISE(raise), .BUS_INTERRUPT_ACK(ack), .VGA_VS(vs),
    .FB_ADDR(fb_addr), .FB_WDATA(fb_wdata), .FB_WE(fb_we), .FB_RDATA(fb_rdata),
    .CONFIG_COLOURS(colours)
  );

  // Frame-buffer model: synchronous write, read data one cycle after address.
  always @(posedge clk) begin
    fb_rdata <= fb_mem[fb_addr];
    if (fb_we) fb_mem[fb_addr] <= fb_wdata;
  end

  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      n_checks++;
      if (fb_q.size() == 0) begin
        n_fails++;
        $display("FAIL fb_write_unexpected: got addr=%h data=%b, required no write", fb_addr, fb_wdata);
      end else begin
        logic [15:0] e;
        e = fb_q.pop_front();
        if ({fb_addr, fb_wdata} !== e) begin
          n_fails++;
          $display("FAIL fb_write: got addr=%h data=%b, required addr=%h data=%b",
                   fb_addr, fb_wdata, e[15:1], e[0]);
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1; drive_en = 1'b1;
    cyc;
    bus_we = 1'b0; drive_en = 1'b0; bus_addr = 8'h00;
  endtask

  // One read cycle, sample the driven data, then idle long enough for any refresh to finish.
  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    bus_addr = a; bus_we = 1'b0;
    cyc;
    d = bus_data;
    bus_addr = 8'h00;
    cyc; cyc;
  endtask

  task automatic test_reset;
    logic [7:0] got, e;
    logic [7:0] offs [6];
    offs = '{8'd0, 8'd1, 8'd3, 8'd4, 8'd5, 8'd6};
    n_checks++;
    if ({fb_we, fb_addr, fb_wdata, raise, colours} !== 34'h0) begin
      n_fails++;
      $display("FAIL reset_outputs: got we=%b addr=%h wd=%b raise=%b col=%h, required all 0",
               fb_we, fb_addr, fb_wdata, raise, colours);
    end
    foreach (offs[i]) begin
      rd_q.push_back(8'h00);
      bus_read(8'hB0 + offs[i], got);
      e = rd_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fails++;
        $display("FAIL reset_reg[%0d]: got %h, required %h", offs[i], got, e);
      end
    end
  endtask

  task automatic test_write;
    logic [7:0] got, e, ex, ey;
    bus_write(8'hB0, 8'd5);
    bus_write(8'hB1, 8'd3);
    fb_q.push_back({15'h0305, 1'b1});
    bus_write(8'hB2, 8'h01);
    cyc; cyc;
    n_checks++;
    if (fb_q.size() != 0) begin n_fails++; $display("FAIL write_5_3: got %0d pending, required 0", fb_q.size()); end
    rd_q.push_back(8'h00);
    bus_read(8'hB3, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL write_status: got %h, required %h", got, e); end
`ifdef VGA_PIXEL_BRIDGE_AUTOINC_EN
    ex = 8'd6;
`else
    ex = 8'd5;
`endif
    rd_q.push_back(ex);
    bus_read(8'hB0, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL write_x_after: got %h, required %h", got, e); end

    // Bottom-right corner is the last valid pixel.
    bus_write(8'hB0, 8'd159);
    bus_write(8'hB1, 8'd119);
    fb_q.push_back({15'h779F, 1'b1});
    bus_write(8'hB2, 8'h01);
    n_checks++;
    if (fb_we !== 1'b1 || fb_addr !== 15'h779F) begin
      n_fails++; $display("FAIL corner_addr: got we=%b addr=%h, required we=1 addr=779f", fb_we, fb_addr);
    end
    cyc; cyc;
    n_checks++;
    if (fb_q.size() != 0) begin n_fails++; $display("FAIL corner_write: got %0d pending, required 0", fb_q.size()); end
`ifdef VGA_PIXEL_BRIDGE_AUTOINC_EN
    ex = 8'd0; ey = 8'd0;
`else
    ex = 8'd159; ey = 8'd119;
`endif
    rd_q.push_back(ex); rd_q.push_back(ey);
    bus_read(8'hB0, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL corner_x: got %h, required %h", got, e); end
    bus_read(8'hB1, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL corner_y: got %h, required %h", got, e); end
  endtask

  task automatic test_range_err;
    logic [7:0] got, e;
    logic [7:0] xs [2];
    logic [7:0] ys [2];
    xs = '{8'd160, 8'd0};
    ys = '{8'd0, 8'd120};
    foreach (xs[i]) begin
      bus_write(8'hB0, xs[i]);
      bus_write(8'hB1, ys[i]);
      bus_write(8'hB2, 8'h01);
      cyc; cyc;
      rd_q.push_back(8'h02); rd_q.push_back(8'h00);
      bus_read(8'hB3, got); e = rd_q.pop_front();
      n_checks++;
      if (got !== e) begin n_fails++; $display("FAIL range_status[%0d]: got %h, required %h", i, got, e); end
      bus_write(8'hB3, 8'hFF);
      bus_read(8'hB3, got); e = rd_q.pop_front();
      n_checks++;
      if (got !== e) begin n_fails++; $display("FAIL range_clear[%0d]: got %h, required %h", i, got, e); end
    end
    rd_q.push_back(8'd0);
    bus_read(8'hB0, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL range_x_kept: got %h, required %h", got, e); end
  endtask

  task automatic test_colours;
    logic [7:0] got, e;
    bus_write(8'hB4, 8'h12);
    n_checks++;
    if (colours !== 16'h0012) begin n_fails++; $display("FAIL colours_bg: got %h, required 0012", colours); end
    bus_write(8'hB5, 8'hAB);
    n_checks++;
    if (colours !== 16'hAB12) begin n_fails++; $display("FAIL colours_fg: got %h, required ab12", colours); end
    rd_q.push_back(8'hAB);
    bus_read(8'hB5, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL fg_read: got %h, required %h", got, e); end
  endtask

  task automatic test_read_refresh;
    logic [7:0] got, e;
    bus_write(8'hB0, 8'd10);
    bus_write(8'hB1, 8'd20);
    fb_q.push_back({15'h140A, 1'b1});
    bus_write(8'hB2, 8'h01);
    bus_write(8'hB0, 8'd10);
    cyc;
    // First PIXEL read: stale 0, then STATUS shows busy for two cycles.
    rd_q.push_back(8'h00); rd_q.push_back(8'h01); rd_q.push_back(8'h01); rd_q.push_back(8'h00);
    bus_addr = 8'hB2; bus_we = 1'b0;
    cyc;
    got = bus_data; e = rd_q.pop_front();
    n_checks++;
    if (got !== e || fb_addr !== 15'h140A) begin
      n_fails++; $display("FAIL refresh_first: got data=%h addr=%h, required data=%h addr=140a", got, fb_addr, e);
    end
    bus_addr = 8'hB3;
    for (int k = 0; k < 3; k++) begin
      cyc;
      got = bus_data; e = rd_q.pop_front();
      n_checks++;
      if (got !== e) begin n_fails++; $display("FAIL refresh_busy[%0d]: got %h, required %h", k, got, e); end
    end
    bus_addr = 8'h00;
    cyc;
    rd_q.push_back(8'h01);
    bus_read(8'hB2, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL refresh_second: got %h, required %h", got, e); end
  endtask

  task automatic test_busy_and_oor_read;
    logic [7:0] got, e;
    bus_addr = 8'hB2; bus_we = 1'b0;
    cyc; cyc;
    bus_addr = 8'h00;
    cyc; cyc;
    rd_q.push_back(8'h02);
    bus_read(8'hB3, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL busy_pixel_err: got %h, required %h", got, e); end
    bus_write(8'hB3, 8'h00);
    // Out-of-range read must not touch the frame buffer (that location holds 0).
    bus_write(8'hB0, 8'd160);
    bus_read(8'hB2, got);
    rd_q.push_back(8'h01); rd_q.push_back(8'h02);
    bus_write(8'hB0, 8'd10);
    bus_read(8'hB2, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL oor_read_pixel: got %h, required %h", got, e); end
    bus_read(8'hB3, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL oor_read_status: got %h, required %h", got, e); end
    bus_write(8'hB3, 8'h00);
  endtask

  task automatic test_irq;
    logic [7:0] got, e;
    n_checks++;
    if (raise !== 1'b0) begin n_fails++; $display("FAIL irq_idle: got %b, required 0", raise); end
    for (int k = 0; k < 3; k++) begin
      vs = 1'b0; cyc;
      n_checks++;
      if (raise !== 1'b1) begin n_fails++; $display("FAIL irq_edge[%0d]: got %b, required 1", k, raise); end
      vs = 1'b1; cyc; cyc;
    end
    rd_q.push_back(8'd3);
    bus_read(8'hB6, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL frames_3: got %h, required %h", got, e); end
    ack = 1'b1; cyc; ack = 1'b0;
    n_checks++;
    if (raise !== 1'b0) begin n_fails++; $display("FAIL irq_ack: got %b, required 0", raise); end
    vs = 1'b0; ack = 1'b1; cyc; ack = 1'b0; vs = 1'b1;
    n_checks++;
    if (raise !== 1'b1) begin n_fails++; $display("FAIL irq_ack_vs_same: got %b, required 1", raise); end
    rd_q.push_back(8'd4);
    bus_read(8'hB6, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL frames_4: got %h, required %h", got, e); end
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] got, e;
    bus_addr = 8'hB2; bus_we = 1'b0;
    cyc;
    bus_addr = 8'h00; rst = 1'b1;
    cyc;
    rst = 1'b0;
    n_checks++;
    if ({raise, colours, fb_we, fb_addr} !== 33'h0) begin
      n_fails++; $display("FAIL midread_outputs: got raise=%b col=%h we=%b addr=%h, required all 0",
                          raise, colours, fb_we, fb_addr);
    end
    cyc; cyc;
    rd_q.push_back(8'h00); rd_q.push_back(8'h00);
    bus_read(8'hB3, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL midread_status: got %h, required %h", got, e); end
    bus_read(8'hB2, got); e = rd_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL midread_pixel: got %h, required %h", got, e); end
  endtask

  initial begin
    rst = 1'b1; bus_we = 1'b0; drive_en = 1'b0; bus_addr = 8'h00; bus_wdata = 8'h00;
    ack = 1'b0; vs = 1'b1;
    repeat (3) cyc;
    rst = 1'b0;
    cyc;
    test_reset;
    test_write;
    test_range_err;
    test_colours;
    test_read_refresh;
    test_busy_and_oor_read;
    test_irq;
    test_reset_mid_read;
    repeat (4) cyc;
    n_checks++;
    if (fb_q.size() != 0) begin n_fails++; $display("FAIL fb_pending_end: got %0d, required 0", fb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/vga_pixel_bridge.md
# vga_pixel_bridge

Bus-mapped front end for the VGA frame buffer. It sits between the CPU's shared 8-bit data/address bus and the VGA block's 160x120 one-bit frame buffer. It latches X/Y coordinates and colour configuration written by the CPU and issues single-cycle frame-buffer writes and two-cycle reads. It also turns the VGA vertical sync into a frame interrupt held until the CPU acknowledges it.

## Interface
Parameters:
- BASE_ADDR, 8'hB0: bus base address. Registers occupy BASE_ADDR+0 .. BASE_ADDR+6.
- FB_ADDR_W, 15: frame-buffer address width, formed as {Y[6:0], X[7:0]}.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- BUS_DATA  inout  8  CPU data bus; driven only during a read of a mapped address, otherwise high-Z
- BUS_ADDR  in  8  CPU address
- BUS_WE  in  1  bus write strobe
- BUS_INTERRUPT_RAISE  out  1  frame interrupt request
- BUS_INTERRUPT_ACK  in  1  CPU acknowledge, one-cycle pulse
- VGA_VS  in  1  vertical sync from VGA timing, active-low, synchronous to CLK
- FB_ADDR  out  FB_ADDR_W  frame-buffer address
- FB_WDATA  out  1  pixel value
- FB_WE  out  1  frame-buffer write enable
- FB_RDATA  in  1  frame-buffer read data, valid one cycle after FB_ADDR
- CONFIG_COLOURS  out  16  {fg[15:8], bg[7:0]} colour pair for the VGA block

## Operation
Register map (offset from BASE_ADDR):
- 0 X: R/W, 8 bits. Valid range 0..159.
- 1 Y: R/W, 8 bits. Valid range 0..119.
- 2 PIXEL:
  - Write: bit0 is the pixel value and triggers a write.
  - Read: returns {7'b0, last read pixel}.
- 3 STATUS: R.
  - bit0 busy.
  - bit1 sticky range_err.
  - Writing any value clears bit1.
- 4 BG, 5 FG: R/W colour bytes.
- 6 FRAMES: R, 8-bit frame counter. It wraps 255 -> 0.

State machine has three states: IDLE, RD_ADDR, RD_CAPT.
- A bus write to PIXEL is handled in IDLE:
  - If coordinates are in range, FB_WE=1 for exactly one cycle, with FB_ADDR and FB_WDATA registered together. The state stays IDLE.
  - If out of range, nothing is written and range_err is set.
- A bus read of PIXEL in IDLE:
  - Launches a refresh: IDLE -> RD_ADDR (FB_ADDR driven) -> RD_CAPT (FB_RDATA latched into the pixel register) -> IDLE.
  - The read itself returns the previously latched value. Software reads PIXEL twice; the second read returns the refreshed value.
- busy=1 in RD_ADDR and RD_CAPT.
- A PIXEL write or read arriving while busy is ignored and sets range_err.
- Writes to X/Y while busy take effect immediately. The in-flight read uses the address already registered.
- Out-of-range read: no frame-buffer access, the pixel register is unchanged, and range_err is set.

Frame interrupt:
- A falling edge of VGA_VS (registered previous sample) increments FRAMES and sets BUS_INTERRUPT_RAISE.
- RAISE stays high until a BUS_INTERRUPT_ACK.
- If ACK and a new edge occur in the same cycle, set wins and RAISE stays 1.
- Edges while RAISE is already high still increment FRAMES.

Bus reads:
- BUS_DATA is driven on the cycle after a read (BUS_WE=0) of a mapped address, for one cycle.
- Unmapped addresses are never driven.

## Timing
- Reset values:
  - All registers 0.
  - FB_WE=0, FB_ADDR=0, FB_WDATA=0.
  - BUS_INTERRUPT_RAISE=0, CONFIG_COLOURS=16'h0000.
  - BUS_DATA high-Z.
  - State IDLE. Edge detector previous-sample register = 1.
- Reset mid-read aborts to IDLE with no capture.
- Latencies:
  - Bus write to FB_WE: 1 cycle.
  - Read refresh: 2 cycles, busy for both.
  - VS falling edge to RAISE: 1 cycle.
  - ACK to RAISE low: 1 cycle.
  - Register write to CONFIG_COLOURS: 1 cycle.
- Boundaries:
  - X=159, Y=119 is valid.
  - X=160 or Y=120 is out of range.
  - FB_ADDR={Y[6:0],X[7:0]}; Y[7] and X beyond range never reach FB_ADDR.

## Configuration
- VGA_PIXEL_BRIDGE_AUTOINC_EN
  - Defined: after each in-range PIXEL write, X increments. X=159 wraps to 0 and Y increments; Y=119 wraps to 0. The update is visible in the register the same cycle FB_WE is high. Out-of-range writes do not increment.
  - Undefined: X/Y change only on bus writes.

## Test plan
- Write X=5, Y=3, PIXEL=1 -> FB_WE pulses once with FB_ADDR=15'h0305, FB_WDATA=1; STATUS reads 8'h00.
- Write X=160, then PIXEL=1 -> FB_WE never asserts; STATUS=8'h02; writing STATUS clears it to 8'h00.
- FB preloaded with 1 at (10,20); read PIXEL twice -> busy for 2 cycles, second read returns 8'h01.
- Three VS falling edges, no ACK -> RAISE stays high, FRAMES=3. ACK -> RAISE low next cycle. ACK coincident with a 4th edge -> RAISE stays 1, FRAMES=4.
- With AUTOINC_EN, X=159, Y=119, PIXEL write -> FB_ADDR=15'h779F, then X=0, Y=0.
- RESET asserted during RD_ADDR -> state IDLE, busy=0, RAISE=0, CONFIG_COLOURS=0, pixel register unchanged at 0.
